mem_req_sequencer: RTL and testbench
====================================

# mem_req_sequencer

Request front-end placed directly upstream of the AI memory access unit. Buffers memory requests (read, write, add, subtract) from the compute core in an in-order FIFO and issues at most one per cycle onto the access unit's `addr`/`data_in`/`mem_op` inputs. Captures read results from its `data_out` and returns them, tagged, through a credit-protected response queue with valid/ready backpressure.

## Interface
- `DEPTH`, 8: request FIFO entries, power of two ≥ 2
- `RSP_DEPTH`, 2: response queue entries, ≥ 1
- `TAG_W`, 4: request/response tag width
- `MEM_WORDS`, 1024: number of valid word addresses downstream
- `clk` in 1: the single clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `req_valid` in 1: request offered
- `req_ready` out 1: FIFO can accept; `!full && rst_n`
- `req_op` in 2: 00 read, 01 write, 10 add, 11 subtract
- `req_addr` in 32: word address
- `req_data` in 32: write/add/sub operand
- `req_tag` in TAG_W: returned with read response
- `rsp_valid` out 1: response queue head valid
- `rsp_ready` in 1: consumer accepts head
- `rsp_data` out 32: read data
- `rsp_tag` out TAG_W: tag of the originating read
- `rsp_err` out 1: out-of-range read (see Configuration)
- `mem_addr` out 32: registered, to access unit `addr`
- `mem_data` out 32: registered, to access unit `data_in`
- `mem_op` out 2: registered, to access unit `mem_op`
- `mem_rdata` in 32: from access unit `data_out`
- `busy` out 1: FIFO non-empty, read in flight, or `rsp_valid`

## Operation
- Enqueue on `req_valid && req_ready`. Dequeue/issue one head entry per cycle, strictly in order.
- Idle issue slot: `mem_op`=00, `mem_addr`=0, `mem_data`=0. This is a harmless read whose result is discarded.
- Read credits: counter `cred` resets to RSP_DEPTH.
  - Decrement when a read is issued.
  - Increment when a response pops (`rsp_valid && rsp_ready`).
  - Simultaneous issue and pop leaves `cred` unchanged.
- A head read with `cred`=0 stalls the head; nothing behind it is issued. Writes, adds and subs need no credit.
- Read tracking is a 2-stage shift of {valid, tag, err}: issue stage, then execute stage. When the execute-stage entry is valid, `mem_rdata` and its tag are pushed into the response queue. The queue cannot overflow because of the credits.
- Response queue: FIFO of RSP_DEPTH entries {data, tag, err}. Head drives the `rsp_*` outputs.
- Full FIFO with simultaneous pop: `req_ready` stays 0 that cycle. It is computed from the registered count only.
- Tag and address are passed through unchanged. Address wrap and truncation are the access unit's concern.

## Timing
- Reset values: `mem_op`=00, `mem_addr`=0, `mem_data`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_tag`=0, `rsp_err`=0, `busy`=0. FIFOs are empty and `cred`=RSP_DEPTH. `req_ready`=0 while `rst_n` is low.
- Request accepted at edge N into an empty FIFO with no stall:
  - `mem_*` driven after edge N+1.
  - Access unit acts at N+2.
  - For a read, `rsp_valid` goes 1 after N+3.
- Read latency is therefore 3 cycles. Throughput is 1 op/cycle. Sustained reads run at full rate only if the consumer holds `rsp_ready`=1 and RSP_DEPTH ≥ 3; otherwise credits throttle issue.
- Read-after-write to the same address, back to back: the write executes at edge N+2 and the read at N+3, so the read returns the new value.
- Reset mid-operation: the first edge with `rst_n`=0 forces `mem_op`=00 and discards all queued, in-flight and response entries. No write, add or sub is issued after that edge.

## Configuration
- `MEM_SEQ_BOUNDS_CHECK_EN` defined:
  - An entry with `req_addr` ≥ MEM_WORDS is never issued; its slot shows the idle pattern.
  - An out-of-range write, add or sub is silently dropped.
  - An out-of-range read still consumes a credit and returns `rsp_data`=0 and `rsp_err`=1, with the same 3-cycle latency.
- Undefined: every request is issued as-is and `rsp_err` is tied 0.

## Test plan
- Write (01, addr 5, data 0x1234) then read (00, addr 5, tag 3) on consecutive cycles -> `rsp_valid` 3 cycles after the read handshake, with `rsp_data`=0x1234 and `rsp_tag`=3.
- Write 10 to addr 7, add 5, subtract 3, then read -> `rsp_data`=12. `mem_op` sequence observed is 01, 10, 11, 00 on consecutive cycles.
- RSP_DEPTH=2, `rsp_ready`=0, three reads queued -> exactly two reads issued and the third held. Releasing `rsp_ready` for 1 cycle -> the third issues on the following cycle and all tags return in order.
- Push 8 writes with DEPTH=8 and issue stalled behind a credit-blocked read -> `req_ready`=0 at full. One pop -> `req_ready`=1 on the next cycle, with no request lost or duplicated.
- Assert `rst_n`=0 for one cycle while 4 ops are queued and a read is in flight -> `mem_op`=00 from that edge on, `rsp_valid` never asserts for the flushed read, and `busy`=0.
- With `MEM_SEQ_BOUNDS_CHECK_EN`: read addr 1024, tag 9 -> `rsp_err`=1, `rsp_data`=0, `rsp_tag`=9. Write to addr 2000 -> never appears on `mem_op`.

Source files
------------

// File: rtl/mem_req_sequencer_if.sv
// Request/response bundle between the compute core and mem_req_sequencer.
// master = core side, slave = sequencer side.
interface mem_req_sequencer_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_addr;
  logic [31:0]      req_data;
  logic [TAG_W-1:0] req_tag;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_data;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_err;

  modport master (
    output req_valid, req_op, req_addr,
    output req_data, req_tag, rsp_ready,
    input  req_ready, rsp_valid, rsp_data,
    input  rsp_tag, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr,
    input  req_data, req_tag, rsp_ready,
    output req_ready, rsp_valid, rsp_data,
    output rsp_tag, rsp_err
  );
endinterface

// File: rtl/mem_req_sequencer.sv
// In-order request FIFO feeding the memory access unit, with credited read returns.
// Define MEM_SEQ_BOUNDS_CHECK_EN to suppress out-of-range issues and flag reads.
module mem_req_sequencer #(
  parameter int DEPTH     = 8,
  parameter int RSP_DEPTH = 2,
  parameter int TAG_W     = 4,
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  mem_req_sequencer_if.slave bus,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  output logic [1:0]  mem_op,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int RW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int RCW = $clog2(RSP_DEPTH + 1);
  localparam logic [31:0] LIMIT = 32'(MEM_WORDS);
`ifdef MEM_SEQ_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]       op;
    logic [31:0]      addr;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } req_t;

  typedef struct packed {
    logic             v;
    logic [TAG_W-1:0] tag;
    logic             err;
  } trk_t;

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
    logic             err;
  } rsp_t;

  req_t fifo_q [DEPTH];
  rsp_t rspq_q [RSP_DEPTH];

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [RW-1:0]  rwr_q, rwr_d;
  logic [RW-1:0]  rrd_q, rrd_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [RCW-1:0] cred_q, cred_d;
  trk_t           iss_q, iss_d;
  trk_t           exe_q, exe_d;
  logic [1:0]     op_q, op_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    data_q, data_d;

  req_t head, wr_ent;
  rsp_t rsp_ent;
  logic push, pop, empty, stall, oob;
  logic rd_head, iss_rd, iss_mem;
  logic rpush, rpop;

  function automatic logic [RW-1:0] rnext(
    input logic [RW-1:0] p
  );
    return (p == RW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.req_ready = (cnt_q != CW'(DEPTH)) && rst_n;
  assign bus.rsp_valid = (rcnt_q != '0);
  assign bus.rsp_data  = bus.rsp_valid ? rspq_q[rrd_q].data : '0;
  assign bus.rsp_tag   = bus.rsp_valid ? rspq_q[rrd_q].tag : '0;
  assign bus.rsp_err   = bus.rsp_valid && rspq_q[rrd_q].err;

  assign mem_op   = op_q;
  assign mem_addr = addr_q;
  assign mem_data = data_q;
  assign busy     = !empty || iss_q.v || exe_q.v
                 || bus.rsp_valid;

  always_comb begin
    wr_ent  = '{op:   bus.req_op,
                addr: bus.req_addr,
                data: bus.req_data,
                tag:  bus.req_tag};
    head    = fifo_q[rd_ptr_q];
    empty   = (cnt_q == '0);
    push    = bus.req_valid && bus.req_ready;
    rd_head = (head.op == 2'b00);
    oob     = BOUNDS_EN && (head.addr >= LIMIT);
    // a credit-starved read blocks everything behind it
    stall   = rd_head && (cred_q == '0);
    pop     = !empty && !stall;
    iss_rd  = pop && rd_head;
    iss_mem = pop && !oob;
    rpush   = exe_q.v;
    rpop    = bus.rsp_valid && bus.rsp_ready;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    cnt_d    = cnt_q + CW'(push) - CW'(pop);

    op_d   = iss_mem ? head.op : 2'b00;
    addr_d = iss_mem ? head.addr : '0;
    data_d = iss_mem ? head.data : '0;

    iss_d = '{v: iss_rd, tag: head.tag, err: oob};
    exe_d = iss_q;

    rsp_ent = '{data: exe_q.err ? '0 : mem_rdata,
                tag:  exe_q.tag,
                err:  exe_q.err};
    rwr_d   = rpush ? rnext(rwr_q) : rwr_q;
    rrd_d   = rpop ? rnext(rrd_q) : rrd_q;
    rcnt_d  = rcnt_q + RCW'(rpush) - RCW'(rpop);
    cred_d  = cred_q - RCW'(iss_rd) + RCW'(rpop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      rwr_q    <= '0;
      rrd_q    <= '0;
      rcnt_q   <= '0;
      cred_q   <= RCW'(RSP_DEPTH);
      iss_q    <= '0;
      exe_q    <= '0;
      op_q     <= 2'b00;
      addr_q   <= '0;
      data_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      rwr_q    <= rwr_d;
      rrd_q    <= rrd_d;
      rcnt_q   <= rcnt_d;
      cred_q   <= cred_d;
      iss_q    <= iss_d;
      exe_q    <= exe_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= wr_ent;
    if (rpush && rst_n) rspq_q[rwr_q] <= rsp_ent;
  end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// Bench for mem_req_sequencer: access-unit model, ordered scoreboard,
// and directed scenarios with literal expectations.
module tb_mem_req_sequencer;

  localparam int DEPTH     = 8;
  localparam int RSP_DEPTH = 2;
  localparam int TAG_W     = 4;
`ifdef MEM_SEQ_BOUNDS_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_req_sequencer_if #(.TAG_W(TAG_W)) bus();

  logic [31:0] mem_addr, mem_data, mem_rdata;
  logic [1:0]  mem_op;
  logic        busy;

  mem_req_sequencer #(
    .DEPTH(DEPTH), .RSP_DEPTH(RSP_DEPTH),
    .TAG_W(TAG_W), .MEM_WORDS(1024)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_op(mem_op), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  // access unit: acts on the registered mem_* one edge later
  bit [31:0] amem [1024];
  always @(posedge clk) begin
    case (mem_op)
      2'b00: mem_rdata <= amem[mem_addr[9:0]];
      2'b01: amem[mem_addr[9:0]] <= mem_data;
      2'b10: amem[mem_addr[9:0]] <= amem[mem_addr[9:0]] + mem_data;
      default: amem[mem_addr[9:0]] <= amem[mem_addr[9:0]] - mem_data;
    endcase
  end

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h want 0x%08h",
               name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  tag;
  } mreq_t;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    int          due;
  } mrsp_t;

  mreq_t rq[$];
  mrsp_t sq[$];
  bit [31:0] ref_mem [1024];
  int tr_op[$];
  int tr_addr[$];
  int tr_cyc[$];
  int samp = 0;
  int outst = 0;
  bit exp_iss = 0;
  bit rst_prev = 0;
  bit started = 0;
  bit precise = 1;

  function automatic bit is_oob(input mreq_t r);
    return BCHK && (r.addr >= 32'd1024);
  endfunction

  task automatic drain_oob();
    mreq_t h;
    while (rq.size() > 0 && is_oob(rq[0])) begin
      h = rq.pop_front();
      if (h.op == 2'b00)
        sq.push_back('{32'd0, h.tag, 1'b1, samp});
    end
  endtask

  // model: one sample per cycle, 1 time unit before the rising edge
  initial begin : compare
    mreq_t h;
    bit iss, exp_v;
    int a;
    forever begin
      @(negedge clk);
      #4;
      samp++;
      if (rst_prev) begin
        rq.delete();
        sq.delete();
        outst = 0;
        exp_iss = 0;
        started = 1;
      end
      if (started) begin
        iss = (mem_op !== 2'b00) || (mem_addr !== 0)
           || (mem_data !== 0);
        if (iss) begin
          drain_oob();
          if (rq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_unexpected: op %0d addr %0d",
                     mem_op, mem_addr);
          end else begin
            h = rq.pop_front();
            check("issue_op", 32'(mem_op), 32'(h.op));
            check("issue_addr", mem_addr, h.addr);
            check("issue_data", mem_data, h.data);
            a = int'(h.addr[9:0]);
            tr_op.push_back(int'(h.op));
            tr_addr.push_back(int'(h.addr));
            tr_cyc.push_back(cyc);
            case (h.op)
              2'b00: begin
                sq.push_back('{ref_mem[a], h.tag, 1'b0, samp + 2});
                outst++;
              end
              2'b01: ref_mem[a] = h.data;
              2'b10: ref_mem[a] = ref_mem[a] + h.data;
              default: ref_mem[a] = ref_mem[a] - h.data;
            endcase
          end
        end
        if (precise) begin
          check("issue_timing", 32'(iss), 32'(exp_iss));
          check("busy", 32'(busy),
                32'(rq.size() > 0 || outst > 0));
          check("req_ready", 32'(bus.req_ready),
                32'(rst_n && rq.size() < DEPTH));
          check("credit_bound", 32'(outst <= RSP_DEPTH), 32'd1);
        end
        exp_iss = rst_n && rq.size() > 0
               && !(rq[0].op == 2'b00 && outst >= RSP_DEPTH);
        exp_v = sq.size() > 0 && sq[0].due <= samp;
        if (precise)
          check("rsp_valid", 32'(bus.rsp_valid), 32'(exp_v));
        if (bus.rsp_valid === 1'b1) begin
          if (sq.size() == 0) drain_oob();
          if (sq.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL rsp_unexpected: tag %0d", bus.rsp_tag);
          end else begin
            check("rsp_data", bus.rsp_data, sq[0].data);
            check("rsp_tag", 32'(bus.rsp_tag), 32'(sq[0].tag));
            check("rsp_err", 32'(bus.rsp_err), 32'(sq[0].err));
            if (bus.rsp_ready && rst_n) begin
              void'(sq.pop_front());
              outst--;
            end
          end
        end
        if (bus.req_valid && bus.req_ready && rst_n) begin
          h = '{bus.req_op, bus.req_addr,
                bus.req_data, bus.req_tag};
          rq.push_back(h);
          if (is_oob(h)) precise = 0;
        end
      end
      rst_prev = !rst_n;
    end
  end

  task automatic send(input logic [1:0] op,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0] t);
    int n = 0;
    bus.req_op = op;
    bus.req_addr = a;
    bus.req_data = d;
    bus.req_tag = t;
    bus.req_valid = 1'b1;
    while (bus.req_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: addr %0d", a);
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: busy %0b", busy);
    end
    @(negedge clk);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int base, pc;
    bit found;
    bus.req_valid = 1'b0;
    bus.req_op = 2'b00;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.req_tag = '0;
    bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check("rst_mem_op", 32'(mem_op), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_rsp_tag", 32'(bus.rsp_tag), 32'd0);
    check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.req_ready), 32'd1);

    // read-after-write, back to back
    send(2'b01, 32'd5, 32'h1234, 4'd0);
    send(2'b00, 32'd5, 32'd0, 4'd3);
    @(negedge clk);
    check("t1_lat1", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_lat2", 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    check("t1_valid", 32'(bus.rsp_valid), 32'd1);
    check("t1_data", bus.rsp_data, 32'h1234);
    check("t1_tag", 32'(bus.rsp_tag), 32'd3);

    // write / add / sub / read chain
    wait_idle();
    base = tr_op.size();
    send(2'b01, 32'd7, 32'd10, 4'd0);
    send(2'b10, 32'd7, 32'd5, 4'd0);
    send(2'b11, 32'd7, 32'd3, 4'd0);
    send(2'b00, 32'd7, 32'd0, 4'd1);
    repeat (3) @(negedge clk);
    check("t2_valid", 32'(bus.rsp_valid), 32'd1);
    check("t2_data", bus.rsp_data, 32'd12);
    check("t2_tag", 32'(bus.rsp_tag), 32'd1);
    check("t2_nops", 32'(tr_op.size() - base), 32'd4);
    if (tr_op.size() - base == 4) begin
      check("t2_op0", 32'(tr_op[base]), 32'd1);
      check("t2_op1", 32'(tr_op[base + 1]), 32'd2);
      check("t2_op2", 32'(tr_op[base + 2]), 32'd3);
      check("t2_op3", 32'(tr_op[base + 3]), 32'd0);
      check("t2_consec",
            32'(tr_cyc[base + 3] - tr_cyc[base]), 32'd3);
    end

    // credit throttling
    wait_idle();
    bus.rsp_ready = 1'b0;
    base = tr_op.size();
    send(2'b00, 32'd1, 32'd0, 4'd4);
    send(2'b00, 32'd2, 32'd0, 4'd5);
    send(2'b00, 32'd3, 32'd0, 4'd6);
    repeat (6) @(negedge clk);
    check("t3_two_issued", 32'(tr_op.size() - base), 32'd2);
    check("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("t3_head_tag", 32'(bus.rsp_tag), 32'd4);
    check("t3_busy", 32'(busy), 32'd1);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    pc = cyc;
    repeat (2) @(negedge clk);
    check("t3_three_issued", 32'(tr_op.size() - base), 32'd3);
    if (tr_op.size() - base == 3) begin
      check("t3_third_cyc", 32'(tr_cyc[base + 2]), 32'(pc + 1));
      check("t3_third_addr", 32'(tr_addr[base + 2]), 32'd3);
    end
    bus.rsp_ready = 1'b1;
    wait_idle();

    // full FIFO behind a credit-blocked read
    bus.rsp_ready = 1'b0;
    base = tr_op.size();
    send(2'b00, 32'd20, 32'd0, 4'd7);
    send(2'b00, 32'd21, 32'd0, 4'd8);
    send(2'b00, 32'd22, 32'd0, 4'd10);
    for (int k = 0; k < 7; k++)
      send(2'b01, 32'(30 + k), 32'(100 + k), 4'd0);
    check("t4_full", 32'(bus.req_ready), 32'd0);
    bus.req_op = 2'b01;
    bus.req_addr = 32'd37;
    bus.req_data = 32'd107;
    bus.req_tag = 4'd0;
    bus.req_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("t4_held", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("t4_pop_edge", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    check("t4_ready_again", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    wait_idle();
    check("t4_all_issued", 32'(tr_op.size() - base), 32'd11);
    check("t4_mem37", amem[37], 32'd107);

    // reset with ops queued and a read in flight
    bus.rsp_ready = 1'b0;
    send(2'b00, 32'd40, 32'd0, 4'd11);
    send(2'b00, 32'd41, 32'd0, 4'd12);
    send(2'b00, 32'd42, 32'd0, 4'd13);
    for (int k = 0; k < 4; k++)
      send(2'b01, 32'(50 + k), 32'(200 + k), 4'd0);
    repeat (3) @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    check("t5_inflight_addr", mem_addr, 32'd42);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    check("t5_op_idle", 32'(mem_op), 32'd0);
    check("t5_busy", 32'(busy), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check("t5_no_op", 32'(mem_op), 32'd0);
      check("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      check("t5_idle", 32'(busy), 32'd0);
    end
    check("t5_no_write", amem[50], 32'd0);

    // out-of-range addresses
    send(2'b00, 32'd1024, 32'd0, 4'd9);
    repeat (3) @(negedge clk);
    check("t6_valid", 32'(bus.rsp_valid), 32'd1);
    check("t6_tag", 32'(bus.rsp_tag), 32'd9);
    check("t6_err", 32'(bus.rsp_err), 32'(BCHK));
    check("t6_data", bus.rsp_data, 32'd0);
    wait_idle();
    base = tr_op.size();
    send(2'b01, 32'd2000, 32'h55, 4'd0);
    send(2'b00, 32'd976, 32'd0, 4'd2);
    repeat (3) @(negedge clk);
    check("t6b_tag", 32'(bus.rsp_tag), 32'd2);
    check("t6b_data", bus.rsp_data, BCHK ? 32'd0 : 32'h55);
    found = 0;
    for (int i = base; i < tr_addr.size(); i++)
      if (tr_addr[i] == 2000) found = 1;
    check("t6b_oob_write_issued", 32'(found), 32'(!BCHK));

    wait_idle();
    repeat (3) @(negedge clk);
    check("drain_rq", 32'(rq.size()), 32'd0);
    check("drain_sq", 32'(sq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
